// File: rtl/rv32_execute_stage.sv
// rv32_execute_stage: RV32I ID immediate/control decode, EX ALU with branch/jump resolution, EX/MEM register
module rv32_execute_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] id_instr,
    output logic [31:0] cu_imm,
    output logic [3:0]  cu_we,
    output logic        cu_wer,
    input  logic [6:0]  ex_op,
    input  logic [2:0]  ex_funct3,
    input  logic        ex_bit30,
    input  logic [31:0] ex_rv1,
    input  logic [31:0] ex_rv2,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_pc,
    input  logic [3:0]  ex_we,
    input  logic        ex_wer,
    input  logic [4:0]  ex_rd,
    input  logic        act,
    output logic [31:0] pc_new,
    output logic        pc_replace,
    output logic        pc_jalr,
    output logic [6:0]  em_op,
    output logic [2:0]  em_funct3,
    output logic [4:0]  em_rd,
    output logic [31:0] em_daddr,
    output logic [3:0]  em_we,
    output logic        em_wer,
    output logic [31:0] em_regdata,
    output logic [31:0] em_dwdata
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic [6:0]  id_op;
    logic [31:0] opb, alu, ex_regdata, daddr, st_data;
    logic [3:0]  st_we;
    logic [4:0]  sh;
    logic        taken, is_jal, is_jalr, redirect;
    logic        flush_q, flush_d;
    logic [6:0]  em_op_q, em_op_d;
    logic [2:0]  em_funct3_q, em_funct3_d;
    logic [4:0]  em_rd_q, em_rd_d;
    logic [31:0] em_daddr_q, em_daddr_d, em_regdata_q, em_regdata_d, em_dwdata_q, em_dwdata_d;
    logic [3:0]  em_we_q, em_we_d;
    logic        em_wer_q, em_wer_d;

    assign id_op = id_instr[6:0];

    // ID-stage immediate extraction and write-enable decode
    always_comb begin
        cu_imm = 32'b0;
        if (id_op == OP_I || id_op == OP_LD || id_op == OP_JALR)
            cu_imm = {{20{id_instr[31]}}, id_instr[31:20]};
        else if (id_op == OP_ST)
            cu_imm = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
        else if (id_op == OP_BR)
            cu_imm = {{19{id_instr[31]}}, id_instr[31], id_instr[7], id_instr[30:25], id_instr[11:8], 1'b0};
        else if (id_op == OP_LUI || id_op == OP_AUIPC)
            cu_imm = {id_instr[31:12], 12'b0};
        else if (id_op == OP_JAL)
            cu_imm = {{11{id_instr[31]}}, id_instr[31], id_instr[19:12], id_instr[20], id_instr[30:21], 1'b0};
        cu_we  = (id_op == OP_ST) ? 4'hF : 4'h0;
        cu_wer = !(id_op == OP_ST || id_op == OP_BR || id_instr == 32'b0);
    end

    // EX-stage ALU and result select; only register-register ops may subtract
    always_comb begin
        opb = (ex_op == OP_R) ? ex_rv2 : ex_imm;
        sh  = opb[4:0];
        alu = 32'b0;
        case (ex_funct3)
            3'd0: alu = (ex_op == OP_R && ex_bit30) ? ex_rv1 - opb : ex_rv1 + opb;
            3'd1: alu = ex_rv1 << sh;
            3'd2: alu = {31'b0, $signed(ex_rv1) < $signed(opb)};
            3'd3: alu = {31'b0, ex_rv1 < opb};
            3'd4: alu = ex_rv1 ^ opb;
            3'd5: alu = ex_bit30 ? $unsigned($signed(ex_rv1) >>> sh) : ex_rv1 >> sh;
            3'd6: alu = ex_rv1 | opb;
            default: alu = ex_rv1 & opb;
        endcase
        ex_regdata = (ex_op == OP_R || ex_op == OP_I) ? alu :
                     (ex_op == OP_LUI)                ? ex_imm :
                     (ex_op == OP_AUIPC)              ? ex_pc + ex_imm :
                     (ex_op == OP_JAL || ex_op == OP_JALR) ? ex_pc + 32'd4 : 32'b0;
    end

    // branch/jump resolution; an annulled instruction must not redirect
    always_comb begin
        case (ex_funct3)
            3'd0: taken = ex_rv1 == ex_rv2;
            3'd1: taken = ex_rv1 != ex_rv2;
            3'd4: taken = $signed(ex_rv1) < $signed(ex_rv2);
            3'd5: taken = $signed(ex_rv1) >= $signed(ex_rv2);
            3'd6: taken = ex_rv1 < ex_rv2;
            3'd7: taken = ex_rv1 >= ex_rv2;
            default: taken = 1'b0;
        endcase
        taken      = taken && ex_op == OP_BR;
        is_jal     = ex_op == OP_JAL;
        is_jalr    = ex_op == OP_JALR;
        redirect   = taken | is_jal | is_jalr;
        pc_replace = redirect & ~flush_q;
        pc_jalr    = is_jalr & ~flush_q;
        pc_new     = is_jalr ? (ex_rv1 + ex_imm) & ~32'h1 : redirect ? ex_pc + ex_imm : 32'b0;
    end

    // store lane alignment from the low address bits
    always_comb begin
        daddr   = ex_rv1 + ex_imm;
        st_we   = 4'h0;
        st_data = ex_rv2;
        if (ex_op == OP_ST && |ex_we) begin
            case (ex_funct3[1:0])
                2'd0: begin
                    st_we   = 4'b0001 << daddr[1:0];
                    st_data = {24'b0, ex_rv2[7:0]} << {daddr[1:0], 3'b0};
                end
                2'd1: begin
                    st_we   = 4'b0011 << {daddr[1], 1'b0};
                    st_data = {16'b0, ex_rv2[15:0]} << {daddr[1], 4'b0};
                end
                default: st_we = 4'hF;
            endcase
        end
    end

    // EX/MEM next state: stall inserts a bubble, flush kills side effects of the captured instruction
    always_comb begin
        flush_d      = act & pc_replace;
        em_op_d      = act ? ex_op : 7'b0;
        em_rd_d      = act ? ex_rd : 5'b0;
        em_we_d      = (act && !flush_q) ? st_we : 4'h0;
        em_wer_d     = act & ex_wer & ~flush_q;
        em_funct3_d  = act ? ex_funct3 : em_funct3_q;
        em_daddr_d   = act ? daddr : em_daddr_q;
        em_regdata_d = act ? ex_regdata : em_regdata_q;
        em_dwdata_d  = act ? st_data : em_dwdata_q;
    end

    // EX/MEM pipeline register with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_q      <= 1'b0;
            em_op_q      <= 7'b0;
            em_funct3_q  <= 3'b0;
            em_rd_q      <= 5'b0;
            em_daddr_q   <= 32'b0;
            em_we_q      <= 4'b0;
            em_wer_q     <= 1'b0;
            em_regdata_q <= 32'b0;
            em_dwdata_q  <= 32'b0;
        end else begin
            flush_q      <= flush_d;
            em_op_q      <= em_op_d;
            em_funct3_q  <= em_funct3_d;
            em_rd_q      <= em_rd_d;
            em_daddr_q   <= em_daddr_d;
            em_we_q      <= em_we_d;
            em_wer_q     <= em_wer_d;
            em_regdata_q <= em_regdata_d;
            em_dwdata_q  <= em_dwdata_d;
        end
    end

    assign em_op      = em_op_q;
    assign em_funct3  = em_funct3_q;
    assign em_rd      = em_rd_q;
    assign em_daddr   = em_daddr_q;
    assign em_we      = em_we_q;
    assign em_wer     = em_wer_q;
    assign em_regdata = em_regdata_q;
    assign em_dwdata  = em_dwdata_q;
endmodule

// File: tb/tb_rv32_execute_stage.sv
// tb_rv32_execute_stage: scoreboard bench for the RV32I decode/execute slice
module tb_rv32_execute_stage;
    localparam logic [6:0] R = 7'h33, I = 7'h13, ST = 7'h23, BR = 7'h63;
    localparam logic [6:0] JAL = 7'h6F, JALR = 7'h67, LUI = 7'h37, AUIPC = 7'h17;

    logic        clk = 1'b0, reset = 1'b0;
    logic [31:0] id_instr = 32'b0, cu_imm;
    logic [3:0]  cu_we;
    logic        cu_wer;
    logic [6:0]  ex_op = 7'b0;
    logic [2:0]  ex_funct3 = 3'b0;
    logic        ex_bit30 = 1'b0;
    logic [31:0] ex_rv1 = 32'b0, ex_rv2 = 32'b0, ex_imm = 32'b0, ex_pc = 32'b0;
    logic [3:0]  ex_we = 4'b0;
    logic        ex_wer = 1'b0;
    logic [4:0]  ex_rd = 5'b0;
    logic        act = 1'b1;
    logic [31:0] pc_new;
    logic        pc_replace, pc_jalr;
    logic [6:0]  em_op;
    logic [2:0]  em_funct3;
    logic [4:0]  em_rd;
    logic [31:0] em_daddr, em_regdata, em_dwdata;
    logic [3:0]  em_we;
    logic        em_wer;

    typedef struct {
        logic [31:0] reg_v, daddr, dw;
        logic [3:0]  we;
        logic        wer;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        bit          ck_reg, ck_dw;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    rv32_execute_stage dut (
        .clk(clk), .reset(reset), .id_instr(id_instr), .cu_imm(cu_imm), .cu_we(cu_we), .cu_wer(cu_wer),
        .ex_op(ex_op), .ex_funct3(ex_funct3), .ex_bit30(ex_bit30), .ex_rv1(ex_rv1), .ex_rv2(ex_rv2),
        .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_we(ex_we), .ex_wer(ex_wer), .ex_rd(ex_rd), .act(act),
        .pc_new(pc_new), .pc_replace(pc_replace), .pc_jalr(pc_jalr), .em_op(em_op), .em_funct3(em_funct3),
        .em_rd(em_rd), .em_daddr(em_daddr), .em_we(em_we), .em_wer(em_wer), .em_regdata(em_regdata),
        .em_dwdata(em_dwdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // drive one EX instruction and push what the EX/MEM register must hold after the next edge
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic b30,
                         input logic [31:0] rv1, input logic [31:0] rv2, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [3:0] we, input logic wer, input logic [4:0] rd,
                         input logic a, input logic [31:0] e_reg, input bit ck_reg,
                         input logic [31:0] e_dw, input bit ck_dw, input logic [3:0] e_we, input logic e_wer);
        exp_t e;
        ex_op = op; ex_funct3 = f3; ex_bit30 = b30; ex_rv1 = rv1; ex_rv2 = rv2; ex_imm = imm;
        ex_pc = pc; ex_we = we; ex_wer = wer; ex_rd = rd; act = a;
        if (a) begin
            e.reg_v = e_reg; e.ck_reg = ck_reg; e.dw = e_dw; e.ck_dw = ck_dw;
            e.daddr = rv1 + imm; e.f3 = f3; e.op = op; e.rd = rd; e.we = e_we; e.wer = e_wer;
        end else begin
            e = last;
            e.op = 7'b0; e.rd = 5'b0; e.we = 4'b0; e.wer = 1'b0;
        end
        last = e;
        sb.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard empty got=0 exp=1");
        end else begin
            e = sb.pop_front();
            if (e.ck_reg) check("em_regdata", em_regdata, e.reg_v);
            if (e.ck_dw) check("em_dwdata", em_dwdata, e.dw);
            check("em_daddr", em_daddr, e.daddr);
            check("em_we", 32'(em_we), 32'(e.we));
            check("em_wer", 32'(em_wer), 32'(e.wer));
            check("em_op", 32'(em_op), 32'(e.op));
            check("em_funct3", 32'(em_funct3), 32'(e.f3));
            check("em_rd", 32'(em_rd), 32'(e.rd));
        end
    endtask

    initial begin
        ex_op = R; ex_rv1 = 32'd5; ex_rv2 = 32'd7; ex_wer = 1'b1; ex_rd = 5'd3;
        repeat (2) @(posedge clk);
        #1;
        check("rst_regdata", em_regdata, 32'b0);
        check("rst_wer", 32'(em_wer), 32'b0);
        check("rst_op", 32'(em_op), 32'b0);
        check("rst_daddr", em_daddr, 32'b0);
        id_instr = 32'hFFF00093; #1;
        check("dec_i_imm", cu_imm, 32'hFFFFFFFF);
        check("dec_i_wer", 32'(cu_wer), 32'd1);
        check("dec_i_we", 32'(cu_we), 32'd0);
        id_instr = 32'hFE112E23; #1;
        check("dec_s_imm", cu_imm, 32'hFFFFFFFC);
        check("dec_s_we", 32'(cu_we), 32'hF);
        check("dec_s_wer", 32'(cu_wer), 32'd0);
        id_instr = 32'hFE000CE3; #1;
        check("dec_b_imm", cu_imm, 32'hFFFFFFF8);
        check("dec_b_wer", 32'(cu_wer), 32'd0);
        id_instr = 32'h123450B7; #1;
        check("dec_u_imm", cu_imm, 32'h12345000);
        id_instr = 32'h010000EF; #1;
        check("dec_j_imm", cu_imm, 32'h00000010);
        id_instr = 32'h0; #1;
        check("dec_zero_wer", 32'(cu_wer), 32'd0);
        check("dec_zero_imm", cu_imm, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        issue(R, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0, 4'd0, 1'b1, 5'd3, 1'b1, 32'd12, 1, 32'd0, 0, 4'd0, 1'b1); step();
        issue(R, 3'd0, 1'b1, 32'd5, 32'd7, 32'd0, 32'd0, 4'd0, 1'b1, 5'd3, 1'b1, 32'hFFFFFFFE, 1, 32'd0, 0, 4'd0, 1'b1); step();
        issue(I, 3'd5, 1'b1, 32'h80000000, 32'd0, 32'h404, 32'd0, 4'd0, 1'b1, 5'd4, 1'b1, 32'hF8000000, 1, 32'd0, 0, 4'd0, 1'b1); step();
        issue(I, 3'd5, 1'b0, 32'h80000000, 32'd0, 32'h4, 32'd0, 4'd0, 1'b1, 5'd4, 1'b1, 32'h08000000, 1, 32'd0, 0, 4'd0, 1'b1); step();
        issue(R, 3'd2, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 4'd0, 1'b1, 5'd8, 1'b1, 32'd1, 1, 32'd0, 0, 4'd0, 1'b1); step();
        issue(R, 3'd3, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 4'd0, 1'b1, 5'd8, 1'b1, 32'd0, 1, 32'd0, 0, 4'd0, 1'b1); step();
        issue(LUI, 3'd0, 1'b0, 32'd0, 32'd0, 32'h12345000, 32'd0, 4'd0, 1'b1, 5'd6, 1'b1, 32'h12345000, 1, 32'd0, 0, 4'd0, 1'b1); step();
        issue(AUIPC, 3'd0, 1'b0, 32'd0, 32'd0, 32'h2000, 32'h1000, 4'd0, 1'b1, 5'd6, 1'b1, 32'h3000, 1, 32'd0, 0, 4'd0, 1'b1); step();
        issue(BR, 3'd1, 1'b0, 32'd3, 32'd3, 32'hFFFFFFF8, 32'h20, 4'd0, 1'b0, 5'd0, 1'b1, 32'd0, 0, 32'd0, 0, 4'd0, 1'b0);
        #1;
        check("bne_replace", 32'(pc_replace), 32'd0);
        check("bne_pc_new", pc_new, 32'd0);
        step();
        issue(BR, 3'd0, 1'b0, 32'd3, 32'd3, 32'hFFFFFFF8, 32'h20, 4'd0, 1'b0, 5'd0, 1'b1, 32'd0, 0, 32'd0, 0, 4'd0, 1'b0);
        #1;
        check("beq_replace", 32'(pc_replace), 32'd1);
        check("beq_pc_new", pc_new, 32'h18);
        check("beq_jalr", 32'(pc_jalr), 32'd0);
        step();
        issue(JAL, 3'd0, 1'b0, 32'd0, 32'd0, 32'h10, 32'h100, 4'd0, 1'b1, 5'd1, 1'b1, 32'h104, 1, 32'd0, 0, 4'd0, 1'b0);
        #1;
        check("annul_replace", 32'(pc_replace), 32'd0);
        step();
        issue(JALR, 3'd0, 1'b0, 32'h101, 32'd0, 32'd2, 32'h40, 4'd0, 1'b1, 5'd5, 1'b1, 32'h44, 1, 32'd0, 0, 4'd0, 1'b1);
        #1;
        check("jalr_replace", 32'(pc_replace), 32'd1);
        check("jalr_pc_new", pc_new, 32'h102);
        check("jalr_flag", 32'(pc_jalr), 32'd1);
        step();
        issue(ST, 3'd2, 1'b0, 32'h100, 32'hDEADBEEF, 32'd0, 32'd0, 4'hF, 1'b0, 5'd0, 1'b1, 32'd0, 0, 32'hDEADBEEF, 1, 4'd0, 1'b0); step();
        issue(ST, 3'd0, 1'b0, 32'h100, 32'hAB, 32'd3, 32'd0, 4'hF, 1'b0, 5'd0, 1'b1, 32'd0, 0, 32'hAB000000, 1, 4'b1000, 1'b0); step();
        issue(ST, 3'd1, 1'b0, 32'h102, 32'h1234, 32'd0, 32'd0, 4'hF, 1'b0, 5'd0, 1'b1, 32'd0, 0, 32'h12340000, 1, 4'b1100, 1'b0); step();
        issue(ST, 3'd2, 1'b0, 32'h200, 32'hDEADBEEF, 32'd4, 32'd0, 4'hF, 1'b0, 5'd0, 1'b1, 32'd0, 0, 32'hDEADBEEF, 1, 4'hF, 1'b0); step();
        issue(R, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0, 4'd0, 1'b1, 5'd3, 1'b1, 32'd12, 1, 32'd0, 0, 4'd0, 1'b1); step();
        issue(R, 3'd0, 1'b0, 32'd1, 32'd1, 32'd0, 32'd0, 4'd0, 1'b1, 5'd7, 1'b0, 32'd0, 0, 32'd0, 0, 4'd0, 1'b0); step();
        issue(R, 3'd4, 1'b0, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 4'd0, 1'b1, 5'd9, 1'b1, 32'h0FF0, 1, 32'd0, 0, 4'd0, 1'b1); step();
        reset = 1'b0;
        #1;
        check("mid_rst_regdata", em_regdata, 32'd0);
        check("mid_rst_daddr", em_daddr, 32'd0);
        check("mid_rst_wer", 32'(em_wer), 32'd0);
        check("mid_rst_op", 32'(em_op), 32'd0);
        check("mid_rst_rd", 32'(em_rd), 32'd0);
        check("mid_rst_f3", 32'(em_funct3), 32'd0);
        #20;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
